// File: rtl/tt_um_warriorjacq9.sv
// 4-bit ALU sequencer: fetches an instruction, reads operands from an external
// register file over a request/response bus, and presents result/flag/done.
module tt_um_warriorjacq9 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_RD1,
        S_NEXT,
        S_RD2,
        S_DONE
    } state_t;

    localparam logic [3:0] REQ_IDLE    = 4'b0000;
    localparam logic [3:0] REQ_REGREAD = 4'b0001;
    localparam logic [3:0] REQ_NEXTOP  = 4'b0011;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_req;
    logic       r_done;
    logic [3:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_res;
    logic       r_flag;

    logic [3:0] w_req;
    logic       w_done;
    logic [3:0] w_b;
    logic [4:0] w_sum;
    logic [3:0] w_res;
    logic       w_flag;
    logic       w_unused;

    assign w_unused = &{1'b0, ena, uio_in[7:4]};

    // State register plus operand/result datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_req   <= REQ_IDLE;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_res   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= w_req;
            r_done  <= w_done;
            case (r_state)
                S_FETCH: begin
                    r_op <= ui_in[3:0];
                    r_a  <= ui_in[7:4];
                end
                S_RD1: r_a <= uio_in[3:0];
                S_RD2: begin
                    r_res  <= w_res;
                    r_flag <= w_flag;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                case (ui_in[3:0])
                    4'd2, 4'd4, 4'd5: w_next = S_RD1;
                    4'd1, 4'd3, 4'd6: w_next = S_NEXT;
                    default:          w_next = S_DONE;
                endcase
            end
            S_RD1:   w_next = S_NEXT;
            S_NEXT:  w_next = S_RD2;
            S_RD2:   w_next = S_DONE;
            S_DONE:  w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state so the registered request/done
    // line up with the state they belong to.
    always_comb begin
        w_req  = REQ_IDLE;
        w_done = 1'b0;
        case (w_next)
            S_RD1, S_RD2: w_req  = REQ_REGREAD;
            S_NEXT:       w_req  = REQ_NEXTOP;
            S_DONE:       w_done = 1'b1;
            default:      ;
        endcase
    end

    // B is taken straight off the response bus on the RD2 exit edge
    assign w_b   = uio_in[3:0];
    assign w_sum = {1'b0, r_a} + {1'b0, w_b};

    always_comb begin
        w_res  = r_res;
        w_flag = r_flag;
        case (r_op)
            4'd1, 4'd2: begin
                w_res  = w_sum[3:0];
                w_flag = w_sum[4];
            end
            4'd3, 4'd4: begin
                w_res  = w_b - r_a;
                w_flag = (w_b < r_a);
            end
            4'd5: begin
                w_res  = ~(r_a & w_b);
                w_flag = 1'b0;
            end
            4'd6: begin
                w_res  = w_b >> r_a;
                w_flag = 1'b0;
            end
            default: ;
        endcase
    end

    assign uo_out  = {4'b0000, r_req};
    assign uio_out = {r_done, r_flag, 2'b00, r_res};
    assign uio_oe  = 8'b1100_1111;

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// Directed bench for tt_um_warriorjacq9 with a register-file responder
// (R1=4, R2=5, R3=6, R4=3; NEXTOP answered with index 3).
module tb_tt_um_warriorjacq9;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [7:0] instr;
    logic       hold;
    logic [3:0] regs [16];
    int         total;
    int         bad;

    tt_um_warriorjacq9 dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder keeps index 3 on the bus from NEXTOP until the block idles again
    always @(posedge clk) begin
        if (rst) hold <= 1'b0;
        else if (uo_out[3:0] == 4'b0011) hold <= 1'b1;
        else if (uo_out[3:0] == 4'b0000) hold <= 1'b0;
    end

    assign ui_in  = {(hold || uo_out[3:0] == 4'b0011) ? 4'd3 : instr[7:4], instr[3:0]};
    assign uio_in = (uo_out[3:0] == 4'b0001) ? {4'b0000, regs[ui_in[7:4]]} : 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] ins, input logic [3:0] er,
                       input logic ef, input int el, input logic [15:0] eseq);
        int n;
        logic [15:0] seq;
        n = 0;
        seq = '0;
        instr = ins;
        while (1) begin
            @(posedge clk); #1;
            n++;
            seq = {seq[11:0], uo_out[3:0]};
            if (uio_out[7] || n >= 12) break;
        end
        chk({tag, "_done"}, {15'd0, uio_out[7]}, 16'd1);
        chk({tag, "_lat"}, n[15:0], el[15:0]);
        chk({tag, "_res"}, {12'd0, uio_out[3:0]}, {12'd0, er});
        chk({tag, "_flag"}, {15'd0, uio_out[6]}, {15'd0, ef});
        chk({tag, "_seq"}, seq, eseq);
        chk({tag, "_pad"}, {8'd0, uo_out[7:4], uio_out[5:4], 2'b00}, 16'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {15'd0, uio_out[7]}, 16'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        foreach (regs[i]) regs[i] = 4'd0;
        regs[1] = 4'd4;
        regs[2] = 4'd5;
        regs[3] = 4'd6;
        regs[4] = 4'd3;
        ena = 1'b1;
        instr = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uo", {8'd0, uo_out}, 16'h0000);
        chk("rst_uio", {8'd0, uio_out}, 16'h0000);
        chk("oe", {8'd0, uio_oe}, 16'h00CF);
        rst = 1'b0;

        run("addi2",  8'h21, 4'd8,    1'b0, 3, 16'h0310);
        run("addi10", 8'hA1, 4'd0,    1'b1, 3, 16'h0310);
        run("addi15", 8'hF1, 4'd5,    1'b1, 3, 16'h0310);
        run("add_r2", 8'h22, 4'd11,   1'b0, 4, 16'h1310);
        run("add_r4", 8'h42, 4'd9,    1'b0, 4, 16'h1310);
        run("sub_r4", 8'h44, 4'd3,    1'b0, 4, 16'h1310);
        run("subi2",  8'h23, 4'd4,    1'b0, 3, 16'h0310);
        run("subi7",  8'h73, 4'd15,   1'b1, 3, 16'h0310);
        run("nop",    8'h00, 4'd15,   1'b1, 1, 16'h0000);
        run("nand1",  8'h15, 4'b1011, 1'b0, 4, 16'h1310);
        run("shr1",   8'h16, 4'd3,    1'b0, 3, 16'h0310);
        run("shr2",   8'h26, 4'd1,    1'b0, 3, 16'h0310);
        run("shr5",   8'h56, 4'd0,    1'b0, 3, 16'h0310);
        run("nop9",   8'hC9, 4'd0,    1'b0, 1, 16'h0000);
        run("addi9",  8'h91, 4'd15,   1'b0, 3, 16'h0310);

        // Abort an ADD in RD2 with reset
        instr = 8'h22;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_rd2", {12'd0, uo_out[3:0]}, 16'h0001);
        rst = 1'b1;
        instr = 8'h00;
        @(posedge clk); #1;
        chk("mid_rst_uo", {8'd0, uo_out}, 16'h0000);
        chk("mid_rst_uio", {8'd0, uio_out}, 16'h0000);
        rst = 1'b0;
        run("nop_rst", 8'h00, 4'd0, 1'b0, 1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
